// File: rtl/cpu32_pkg.sv
// Shared CPU32 constants: data/index widths, write-back opcode encoding and
// the decoded write-back lane payload.
package cpu32_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned REG_AW  = $clog2(NREGS);
  localparam int unsigned WB_OP_W = 4;

  localparam logic [WB_OP_W-1:0] WB_NONE  = 4'd0;
  localparam logic [WB_OP_W-1:0] WB_M1    = 4'd1;
  localparam logic [WB_OP_W-1:0] WB_M2    = 4'd2;
  localparam logic [WB_OP_W-1:0] WB_BOTH  = 4'd3;
  localparam logic [WB_OP_W-1:0] WB_CROSS = 4'd4;
  localparam logic [WB_OP_W-1:0] WB_DUP   = 4'd5;

  typedef struct packed {
    logic              we1;
    logic [REG_AW-1:0] wa1;
    logic [XLEN-1:0]   wd1;
    logic              we2;
    logic [REG_AW-1:0] wa2;
    logic [XLEN-1:0]   wd2;
  } wb_lanes_t;

  // Map opcode + raw lanes to destination lanes; disabled lanes carry zeros.
  function automatic wb_lanes_t wb_decode(
    input logic [WB_OP_W-1:0] op,
    input logic [XLEN-1:0]    m1,
    input logic [XLEN-1:0]    m2,
    input logic [REG_AW-1:0]  wa1,
    input logic [REG_AW-1:0]  wa2,
    input logic               proceed
  );
    wb_lanes_t d;
    d = '0;
    case (op)
      WB_M1: begin
        d.we1 = 1'b1; d.wa1 = wa1; d.wd1 = m1;
      end
      WB_M2: begin
        d.we2 = 1'b1; d.wa2 = wa2; d.wd2 = m2;
      end
      WB_BOTH: begin
        d.we1 = 1'b1; d.wa1 = wa1; d.wd1 = m1;
        d.we2 = 1'b1; d.wa2 = wa2; d.wd2 = m2;
      end
      WB_CROSS: begin
        d.we1 = 1'b1; d.wa1 = wa2; d.wd1 = m1;
        d.we2 = 1'b1; d.wa2 = wa1; d.wd2 = m2;
      end
      WB_DUP: begin
        d.we1 = 1'b1; d.wa1 = wa1; d.wd1 = m1;
        d.we2 = 1'b1; d.wa2 = wa2; d.wd2 = m1;
      end
      default: d = '0;
    endcase
    if (!proceed) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// General register file: two write ports (lane 2 wins on equal index), two
// combinational read ports, register 0 hardwired to zero.
module regfile_2r2w
  import cpu32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we1,
  input  logic [REG_AW-1:0] wa1,
  input  logic [XLEN-1:0]   wd1,
  input  logic              we2,
  input  logic [REG_AW-1:0] wa2,
  input  logic [XLEN-1:0]   wd2,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1_c,
  output logic [XLEN-1:0]   rd2_c
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  // Lane 2 is applied last so it overrides lane 1 on a shared index.
  always_comb begin
    mem_d = mem_q;
    if (we1 && (wa1 != '0)) mem_d[wa1] = wd1;
    if (we2 && (wa2 != '0)) mem_d[wa2] = wd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd1_c = (ra1 == '0) ? '0 : mem_q[ra1];
  assign rd2_c = (ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/reg_writeback_stage.sv
// Write-back stage: captures memory-op results, commits them to the register
// file one edge later. Optional read bypass: REG_WRITEBACK_BYPASS_EN.
module reg_writeback_stage
  import cpu32_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    m1,
  input  logic [XLEN-1:0]    m2,
  input  logic [REG_AW-1:0]  wa1,
  input  logic [REG_AW-1:0]  wa2,
  input  logic [WB_OP_W-1:0] wb_op,
  input  logic               proceed,
  input  logic               hold,
  input  logic [REG_AW-1:0]  ra1,
  input  logic [REG_AW-1:0]  ra2,
  output logic [XLEN-1:0]    rd1,
  output logic [XLEN-1:0]    rd2,
  output logic               fwd_we1,
  output logic [REG_AW-1:0]  fwd_wa1,
  output logic [XLEN-1:0]    fwd_wd1,
  output logic               fwd_we2,
  output logic [REG_AW-1:0]  fwd_wa2,
  output logic [XLEN-1:0]    fwd_wd2,
  output logic               collide
);

  wb_lanes_t       stage_q, stage_d;
  logic            collide_q, collide_d;
  logic            commit_c;
  logic [XLEN-1:0] rf_rd1_c, rf_rd2_c;

  assign commit_c = ~hold;

  // Capture and collision detection both advance only when not stalled.
  always_comb begin
    stage_d   = stage_q;
    collide_d = 1'b0;
    if (commit_c) begin
      stage_d   = wb_decode(wb_op, m1, m2, wa1, wa2, proceed);
      collide_d = stage_q.we1 & stage_q.we2 &
                  (stage_q.wa1 == stage_q.wa2) & (stage_q.wa1 != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q   <= '0;
      collide_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      collide_q <= collide_d;
    end
  end

  regfile_2r2w u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we1   (stage_q.we1 & commit_c),
    .wa1   (stage_q.wa1),
    .wd1   (stage_q.wd1),
    .we2   (stage_q.we2 & commit_c),
    .wa2   (stage_q.wa2),
    .wd2   (stage_q.wd2),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1_c (rf_rd1_c),
    .rd2_c (rf_rd2_c)
  );

`ifdef REG_WRITEBACK_BYPASS_EN
  // Reads see the value committing on the next edge; lane 2 has priority.
  always_comb begin
    rd1 = rf_rd1_c;
    rd2 = rf_rd2_c;
    if (commit_c && (ra1 != '0)) begin
      if (stage_q.we2 && (stage_q.wa2 == ra1))      rd1 = stage_q.wd2;
      else if (stage_q.we1 && (stage_q.wa1 == ra1)) rd1 = stage_q.wd1;
    end
    if (commit_c && (ra2 != '0)) begin
      if (stage_q.we2 && (stage_q.wa2 == ra2))      rd2 = stage_q.wd2;
      else if (stage_q.we1 && (stage_q.wa1 == ra2)) rd2 = stage_q.wd1;
    end
  end
`else
  assign rd1 = rf_rd1_c;
  assign rd2 = rf_rd2_c;
`endif

  assign fwd_we1 = stage_q.we1;
  assign fwd_wa1 = stage_q.wa1;
  assign fwd_wd1 = stage_q.wd1;
  assign fwd_we2 = stage_q.we2;
  assign fwd_wa2 = stage_q.wa2;
  assign fwd_wd2 = stage_q.wd2;
  assign collide = collide_q;

endmodule

// File: doc/reg_writeback_stage.md
Name: reg_writeback_stage

Overview:
- Pipeline stage directly downstream of the memory-op stage. Consumes its m1/m2 results together with the passthrough write-back addresses, write-back opcode and proceed bit.
- Registers these inputs, then commits them to the 32x32-bit general register file that this block owns.
- Provides two combinational read ports for the decode stage, plus forwarding outputs for hazard resolution.

Parameters:
- NREGS, 32, number of architectural registers; must be a power of two; address width is log2(NREGS) = 5.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- m1  in  XLEN  result lane 1 from the memory-op stage.
- m2  in  XLEN  result lane 2 from the memory-op stage.
- wa1  in  5  write-back register index for lane 1.
- wa2  in  5  write-back register index for lane 2.
- wb_op  in  4  write-back opcode.
- proceed  in  1  condition-test result; 0 squashes the write-back.
- hold  in  1  stall; the stage register keeps its contents and no commit occurs.
- ra1  in  5  read address, port 1.
- ra2  in  5  read address, port 2.
- rd1  out  XLEN  read data, port 1.
- rd2  out  XLEN  read data, port 2.
- fwd_we1  out  1  pending lane-1 write valid.
- fwd_wa1  out  5  pending lane-1 destination index.
- fwd_wd1  out  XLEN  pending lane-1 write data.
- fwd_we2  out  1  pending lane-2 write valid.
- fwd_wa2  out  5  pending lane-2 destination index.
- fwd_wd2  out  XLEN  pending lane-2 write data.
- collide  out  1  registered pulse: both lanes targeted the same register in the last commit.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst), i.e. sensitivity is posedge clk or posedge rst.
- On rst:
  - all register-file entries = 0;
  - stage register cleared, which means fwd_we1 = fwd_we2 = 0, fwd_wa* = 0, fwd_wd* = 0;
  - collide = 0.
- Reset in the middle of operation discards any pending commit.
- Capture, edge N (hold = 0): stage register <= {m1, m2, wa1, wa2, decoded enables}. When proceed = 0 the decoded enables are forced to 0.
- wb_op decode:
  - 0: none.
  - 1: m1 -> wa1.
  - 2: m2 -> wa2.
  - 3: both straight (m1 -> wa1, m2 -> wa2).
  - 4: crossed (m1 -> wa2, m2 -> wa1).
  - 5: m1 -> wa1 and m1 -> wa2.
  - 6..15: treated as none.
  - The decoded destination and data are what appear on the fwd_* outputs.
- Commit, edge N+1 (hold = 0): each enabled fwd lane writes fwd_wd to regfile[fwd_wa].
  - Total latency: input to architectural state = 2 edges.
- Register 0 is hardwired to zero: writes to index 0 are dropped, and reads of index 0 return 0. fwd_we* is still driven (the decode stage must ignore index 0).
- Same-destination collision: when both lanes are enabled with equal nonzero addresses, lane 2 wins and collide = 1 for exactly one cycle after the commit edge.
- hold = 1:
  - no capture and no commit; the stage register and fwd_* are frozen;
  - when hold is released, the held entry commits on the next edge, and new inputs are captured on that same edge.
- Reads are combinational from the register file.

Optional Feature:
- Macro: REG_WRITEBACK_BYPASS_EN.
- Defined: rd1/rd2 return fwd_wd of the matching enabled pending lane when the read address equals fwd_wa and is nonzero (lane 2 has priority), so reads see the value that commits at the next edge. No bypass while hold = 1.
- Undefined: rd1/rd2 show register-file contents only, and the decode stage resolves hazards with fwd_*.

Decomposition:
- Shared package cpu32_pkg: the wb_op encoding constants (WB_NONE, WB_M1, WB_M2, WB_BOTH, WB_CROSS, WB_DUP), XLEN, and the register-index width.
- Sub-module regfile_2r2w: storage, two write ports with lane-2 priority, the r0 rule, and the asynchronous reset.
- The stage logic (decode, stage register, hold, bypass) stays in the top module.

Test Plan:
- Reset mid-stream: wb_op=1, m1=0xDEADBEEF, wa1=3, then rst asserted before the commit edge -> regfile[3]=0, fwd_we1=0.
- Straight write: wb_op=3, m1=0x11, wa1=4, m2=0x22, wa2=5, proceed=1 -> fwd valid after edge 1; rd of reg 4 = 0x11 and reg 5 = 0x22 after edge 2.
- Crossed write and squash: wb_op=4, m1=0xA, m2=0xB, wa1=6, wa2=7 -> r6=0xB, r7=0xA. The same stimulus with proceed=0 -> r6 and r7 unchanged, fwd_we*=0.
- Collision and r0: wb_op=3, wa1=wa2=9, m1=1, m2=2 -> r9=2, collide pulses high for 1 cycle. wb_op=1, wa1=0, m1=5 -> rd of reg 0 = 0.
- Hold: capture wb_op=1, wa1=8, m1=0x55, then hold=1 for 3 cycles -> r8 unchanged and fwd_* stable; after hold drops, r8=0x55 on the next edge.
- Bypass: with REG_WRITEBACK_BYPASS_EN, pending r10=0x77 and ra1=10 -> rd1=0x77 before the commit edge. Without the macro -> old value until the commit edge.
